psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Streaming saturating partial-sum accumulator for the ESPNet convolution datapath. It consumes the registered 17-bit signed partial sums produced by the pairwise saturating adder stage. It folds a runtime-programmed number of consecutive terms into one saturated result per output pixel and presents that result downstream with a valid/ready handshake and a per-group saturation flag.

## Interface
- DATA_WIDTH, 17, signed width of input terms and of the result
- COUNT_WIDTH, 8, width of the term counter and of num_terms

- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clock clock
- num_terms  input  COUNT_WIDTH  terms per group; sampled only on the first beat of a group; 0 treated as 1
- in_valid  input  1  in_data holds a term
- in_ready  output  1  block accepts a term this cycle
- in_data  input  DATA_WIDTH  signed two's-complement term
- out_valid  output  1  out_data/out_sat hold a completed group
- out_ready  input  1  downstream accepts the result
- out_data  output  DATA_WIDTH  saturated group sum
- out_sat  output  1  at least one addition in the group saturated

## Operation
- Beat: in_valid & in_ready in the same cycle. Output transfer: out_valid & out_ready in the same cycle.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a beat: acc<=in_data, cnt<=1, target<=max(num_terms,1), sat<=0.
  - Go to HOLD if target==1, else to ACCUM.
- ACCUM:
  - in_ready=1.
  - On a beat: acc<=satadd(acc,in_data), sat<=sat|ovf, cnt<=cnt+1.
  - Go to HOLD when cnt+1==target.
  - No beat: hold all state.
- HOLD:
  - out_valid=1, out_data=acc, out_sat=sat.
  - in_ready=out_ready (combinational pass-through).
  - out_ready & in_valid: transfer, and that beat starts a new group exactly as from IDLE. Next state is HOLD or ACCUM per the new target.
  - out_ready & !in_valid: go to IDLE.
  - !out_ready: all outputs stable, no input accepted.
- satadd(a,b): s=a+b truncated to DATA_WIDTH.
  - a,b negative and s non-negative: result -2^(DATA_WIDTH-1), ovf=1.
  - a,b non-negative and s negative: result 2^(DATA_WIDTH-1)-1, ovf=1.
  - Otherwise: result s, ovf=0.
- Saturation is applied per addition, not at the end. Later terms may pull a saturated accumulator back into range; out_sat stays set.
- num_terms changes while a group is in ACCUM are ignored.

## Timing
- Reset values: in_ready=0 during reset cycle; after reset: state IDLE, out_valid=0, out_data=0, out_sat=0, acc=0, cnt=0.
- Reset mid-group or in HOLD discards the group; no partial result is emitted.
- Latency: out_valid rises the cycle after the beat carrying the final term of a group.
- Throughput: one term per cycle. With out_ready held 1, N-term groups sustain 100% input utilisation, and the HOLD cycle overlaps the next group's first beat.
- out_data and out_sat are registered; out_valid and in_ready are decoded from state and out_ready.
- out_data/out_sat must not change while out_valid=1 and out_ready=0.

## Structure
- Shared package espnet_pkg:
  - DATA_WIDTH default.
  - SAT_MAX/SAT_MIN constants derived from width.
  - State enum (IDLE, ACCUM, HOLD).
- Sub-module espnet_sat_add: combinational saturating adder. Inputs a, b; outputs sum, ovf. Parameterised by DATA_WIDTH. Reused by other stages needing an unregistered saturating sum.
- Top: FSM, counter, accumulator register, output register.

## Test plan
- Reset then num_terms=4, terms 100,-30,7,1, out_ready=1 -> out_valid one cycle after 4th beat, out_data=78, out_sat=0, back-to-back group accepted in HOLD cycle.
- num_terms=3, terms 40000,40000,-20000 -> out_data=45535 (65535-20000), out_sat=1.
- num_terms=2, terms -40000,-40000 -> out_data=-65536, out_sat=1. Then num_terms=0 with term 5 -> single-term group, out_data=5, out_sat=0.
- Result pending with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, out_data stable. out_ready=1 -> result transferred and next first beat accepted the same cycle.
- Reset asserted after 2 of 4 terms -> no out_valid. The next 4-term group 1,1,1,1 -> out_data=4.
- Random valid/ready throttling, 1000 groups, num_terms 1..255 -> matches saturating reference model, with no lost or duplicated terms.

Source files
------------

// File: rtl/espnet_pkg.sv
// Shared definitions for the ESPNet convolution datapath.
//   DATA_WIDTH  - default signed width of partial sums
//   COUNT_WIDTH - default width of the per-group term counter
//   SAT_MAX/MIN - saturation rails derived from DATA_WIDTH
//   state_e     - accumulator FSM states
package espnet_pkg;

    localparam int DATA_WIDTH  = 17;
    localparam int COUNT_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/espnet_sat_add.sv
// Combinational two's-complement saturating adder.
//   a, b : signed operands, DATA_WIDTH bits
//   sum  : a+b clamped to the representable range
//   ovf  : the clamp was applied
module espnet_sat_add
    import espnet_pkg::*;
#(
    parameter int DATA_WIDTH = espnet_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  ovf
);

    localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] raw;
    logic                  pos_ovf;
    logic                  neg_ovf;

    assign raw = a + b;

    // Overflow only possible when operand signs agree and the result sign differs.
    assign pos_ovf = ~a[DATA_WIDTH-1] & ~b[DATA_WIDTH-1] &  raw[DATA_WIDTH-1];
    assign neg_ovf =  a[DATA_WIDTH-1] &  b[DATA_WIDTH-1] & ~raw[DATA_WIDTH-1];

    always_comb begin
        sum = raw;
        if (pos_ovf) sum = MAXV;
        if (neg_ovf) sum = MINV;
    end

    assign ovf = pos_ovf | neg_ovf;

endmodule

// File: rtl/psum_accumulator.sv
// Streaming saturating partial-sum accumulator.
// Folds num_terms consecutive signed terms into one saturated result and
// hands it downstream over valid/ready, with a sticky per-group saturation flag.
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   num_terms             - group length, sampled on a group's first beat (0 -> 1)
//   in_valid/in_ready     - input term handshake, in_data signed term
//   out_valid/out_ready   - result handshake, out_data sum, out_sat sticky flag
module psum_accumulator
    import espnet_pkg::*;
#(
    parameter int DATA_WIDTH  = espnet_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = espnet_pkg::COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] num_terms,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sat
);

    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] target_q, target_d;
    logic                   sat_q, sat_d;

    logic                   ready_raw;
    logic                   beat;
    logic [DATA_WIDTH-1:0]  add_sum;
    logic                   add_ovf;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic [COUNT_WIDTH-1:0] first_target;

    espnet_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign cnt_inc      = cnt_q + ONE;
    assign first_target = (num_terms == '0) ? ONE : num_terms;

    // Ready is held low while reset is asserted so no beat is counted on that edge.
    assign in_ready = ready_raw & ~reset;
    assign beat     = in_valid & in_ready;

    assign out_data = acc_q;
    assign out_sat  = sat_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        sat_d     = sat_q;
        ready_raw = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_raw = 1'b1;
            end
            ACCUM: begin
                ready_raw = 1'b1;
            end
            HOLD: begin
                out_valid = 1'b1;
                // Accepting a term here is only safe once the result leaves.
                ready_raw = out_ready;
                if (out_ready && !in_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            if (state_q == ACCUM) begin
                acc_d = add_sum;
                sat_d = sat_q | add_ovf;
                cnt_d = cnt_inc;
                if (cnt_inc == target_q) state_d = HOLD;
            end else begin
                // First beat of a group, either from IDLE or overlapping HOLD.
                acc_d    = in_data;
                cnt_d    = ONE;
                target_d = first_target;
                sat_d    = 1'b0;
                state_d  = (first_target == ONE) ? HOLD : ACCUM;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            target_q <= ONE;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    localparam int DW   = 17;
    localparam int CW   = 8;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic          clock;
    logic          reset;
    logic [CW-1:0] num_terms;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;

    psum_accumulator dut (
        .clock     (clock),
        .reset     (reset),
        .num_terms (num_terms),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int data;
        bit sat;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    // reference model state: group open, running sum, terms seen, group length
    bit m_open = 0;
    int m_acc, m_cnt, m_tgt;
    bit m_sat;

    bit rdy_rand = 0;
    bit rdy_force = 1;
    int rdy_prob = 100;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rand_term();
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       return int'($urandom_range(0, 131071)) - 65536;
            1:       return ($urandom_range(0, 1) == 1 ? 1 : -1) * int'($urandom_range(30000, 65535));
            default: return int'($urandom_range(0, 400)) - 200;
        endcase
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = rdy_rand ? (int'($urandom_range(0, 99)) < rdy_prob) : rdy_force;
        end
    end

    // Monitor + behavioural reference model, sampled mid-cycle.
    initial begin
        bit   prev_stall = 0;
        int   prev_data = 0;
        bit   prev_sat = 0;
        int   d, s;
        res_t r;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("in_ready_in_reset", int'(in_ready), 0);
                exp_q.delete();
                m_open = 0;
                prev_stall = 0;
            end else begin
                chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
                chk("in_ready", int'(in_ready), (exp_q.size() == 0) ? 1 : int'(out_ready));
                if (prev_stall) begin
                    chk("stall_data", int'($signed(out_data)), prev_data);
                    chk("stall_sat", int'(out_sat), int'(prev_sat));
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = int'($signed(out_data));
                prev_sat   = out_sat;
                if (out_valid && out_ready) begin
                    n_out++;
                    r.data = int'($signed(out_data));
                    r.sat  = out_sat;
                    got_q.push_back(r);
                    if (exp_q.size() != 0) begin
                        res_t e;
                        e = exp_q.pop_front();
                        chk("out_data", r.data, e.data);
                        chk("out_sat", int'(r.sat), int'(e.sat));
                    end
                end
                if (in_valid && in_ready) begin
                    d = int'($signed(in_data));
                    if (!m_open) begin
                        m_tgt  = (num_terms == 0) ? 1 : int'(num_terms);
                        m_acc  = d;
                        m_cnt  = 1;
                        m_sat  = 0;
                        m_open = 1;
                    end else begin
                        s = m_acc + d;
                        if (s > MAXV) begin s = MAXV; m_sat = 1; end
                        if (s < MINV) begin s = MINV; m_sat = 1; end
                        m_acc = s;
                        m_cnt++;
                    end
                    if (m_cnt == m_tgt) begin
                        r.data = m_acc;
                        r.sat  = m_sat;
                        exp_q.push_back(r);
                        m_open = 0;
                    end
                end
            end
        end
    end

    // Present one term until accepted; waits = cycles it was refused or idle.
    task automatic send_term(input int data, input int nt, input int vprob, output int waits);
        bit acc;
        waits = 0;
        acc   = 0;
        while (!acc) begin
            in_valid  = (vprob >= 100) || (int'($urandom_range(0, 99)) < vprob);
            in_data   = data[DW-1:0];
            num_terms = nt[CW-1:0];
            @(negedge clock);
            acc = in_valid && in_ready;
            @(posedge clock);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 2000) begin
                    chk("term_accept_timeout", 0, 1);
                    acc = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_group(input int nt, input int cnt, input int v0, input int v1,
                              input int v2, input int v3, output int wsum);
        int w;
        int v[4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        wsum = 0;
        for (int i = 0; i < cnt; i++) begin
            send_term(v[i], (i == 0) ? nt : int'($urandom_range(0, 255)), 100, w);
            wsum += w;
        end
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(posedge clock);
            k++;
        end
        #1;
        if (got_q.size() < n) chk("result_timeout", got_q.size(), n);
    endtask

    task automatic pop_check(input string name, input int ed, input int es);
        res_t r;
        if (got_q.size() == 0) begin
            chk({name, "_missing"}, 0, 1);
        end else begin
            r = got_q.pop_front();
            chk({name, "_data"}, r.data, ed);
            chk({name, "_sat"}, int'(r.sat), es);
        end
    endtask

    initial begin
        int w, base, k;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        num_terms = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clock);
        #1;

        // basic group followed by a back-to-back group entering during HOLD
        send_group(4, 4, 100, -30, 7, 1, w);
        send_group(4, 4, 1, 2, 3, 4, w);
        chk("back_to_back_waits", w, 0);
        wait_got(2);
        pop_check("grp78", 78, 0);
        pop_check("grp10", 10, 0);

        send_group(3, 3, 40000, 40000, -20000, 0, w);
        wait_got(1);
        pop_check("pos_sat", 45535, 1);

        send_group(2, 2, -40000, -40000, 0, 0, w);
        send_group(0, 1, 5, 0, 0, 0, w);
        wait_got(2);
        pop_check("neg_sat", -65536, 1);
        pop_check("zero_terms", 5, 0);

        // result held with out_ready low while the next term waits
        rdy_force = 0;
        @(posedge clock);
        #1;
        send_term(9, 1, 100, w);
        fork
            send_term(6, 1, 100, w);
            begin
                repeat (5) @(posedge clock);
                rdy_force = 1;
            end
        join
        chk("stall_waits_ge5", int'(w >= 5), 1);
        wait_got(2);
        pop_check("stalled", 9, 0);
        pop_check("after_stall", 6, 0);

        // reset mid-group discards the partial sum
        send_term(10, 4, 100, w);
        send_term(20, 0, 100, w);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        @(posedge clock);
        #1;
        send_group(4, 4, 1, 1, 1, 1, w);
        wait_got(1);
        chk("midrst_no_extra", got_q.size(), 1);
        pop_check("after_reset", 4, 0);

        // randomized throttling against the reference model
        base     = n_out;
        rdy_prob = 70;
        rdy_rand = 1;
        for (int g = 0; g < 1000; g++) begin
            int n, vp;
            n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 255)) : int'($urandom_range(1, 12));
            vp = int'($urandom_range(50, 100));
            for (int i = 0; i < n; i++)
                send_term(rand_term(), (i == 0) ? n : int'($urandom_range(0, 255)), vp, w);
        end
        k = 0;
        while ((exp_q.size() != 0 || m_open) && k < 3000) begin
            @(posedge clock);
            k++;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("random_group_count", n_out - base, 1000);
        chk("random_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clock);
        chk("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
